// File: rtl/ppu_input_stage.sv
// rtl/ppu_input_stage.sv - PPU operand-conditioning input stage with 2-entry skid buffer
package ppu_input_stage_pkg;
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_DIV   = 3'd3,
        OP_FMADD = 3'd4,
        OP_F2P   = 3'd5,
        OP_P2F   = 3'd6
    } operation_e;
    localparam int OP_W = $bits(operation_e);
endpackage

module ppu_input_stage
    import ppu_input_stage_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [OP_W-1:0] op_i,
    input  logic [N-1:0]    p1_i,
    input  logic [N-1:0]    p2_i,
    input  logic [N-1:0]    p3_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [OP_W-1:0] op_o,
    output logic [N-1:0]    p1_o,
    output logic [N-1:0]    p2_o,
    output logic [N-1:0]    p3_o,
    output logic            special_tag_o,
    output logic [N-1:0]    special_val_o,
    output logic [CNT_W-1:0] special_cnt_o
);
    localparam logic [N-1:0] ZERO  = '0;
    localparam logic [N-1:0] NAR   = {1'b1, {(N-1){1'b0}}};
    localparam int           ENT_W = OP_W + 4*N + 1;

    function automatic logic [N-1:0] c2(input logic [N-1:0] x);
        return ~x + N'(1);
    endfunction

    function automatic logic [N-1:0] mag(input logic [N-1:0] x);
        return x[N-1] ? c2(x) : x;
    endfunction

    logic [N-1:0]    q2, c_p1, c_p2, c_val;
    logic [OP_W-1:0] c_op;
    logic            c_tag, is_addsub, nar_hit, swap;
    logic [ENT_W-1:0] in_ent;

    always_comb begin
        is_addsub = (op_i == OP_ADD) || (op_i == OP_SUB);
        q2        = (op_i == OP_SUB) ? c2(p2_i) : p2_i;
        swap      = is_addsub && (mag(q2) > mag(p1_i));
        c_p1      = swap ? q2 : p1_i;
        c_p2      = swap ? p1_i : q2;
        c_op      = (op_i == OP_SUB) ? OP_ADD : op_i;
        nar_hit   = (p1_i == NAR) || (p2_i == NAR) || ((op_i == OP_FMADD) && (p3_i == NAR));
        c_tag     = 1'b0;
        c_val     = ZERO;
        // Priority ladder: NaR dominates, then per-op zero rules; conversions are never special
        case (op_i)
            OP_ADD, OP_SUB: begin
                if (nar_hit)                   begin c_tag = 1'b1; c_val = NAR;  end
                else if (p1_i == ZERO)         begin c_tag = 1'b1; c_val = q2;   end
                else if (p2_i == ZERO)         begin c_tag = 1'b1; c_val = p1_i; end
                else if (p1_i == c2(q2))       begin c_tag = 1'b1; c_val = ZERO; end
            end
            OP_MUL: begin
                if (nar_hit)                   begin c_tag = 1'b1; c_val = NAR;  end
                else if (p1_i == ZERO || p2_i == ZERO) begin c_tag = 1'b1; c_val = ZERO; end
            end
            OP_DIV: begin
                if (nar_hit)                   begin c_tag = 1'b1; c_val = NAR;  end
                else if (p2_i == ZERO)         begin c_tag = 1'b1; c_val = NAR;  end
                else if (p1_i == ZERO)         begin c_tag = 1'b1; c_val = ZERO; end
            end
            OP_FMADD: begin
                if (nar_hit)                   begin c_tag = 1'b1; c_val = NAR;  end
                else if (p1_i == ZERO || p2_i == ZERO) begin c_tag = 1'b1; c_val = p3_i; end
            end
            default: begin
                c_tag = 1'b0;
                c_val = ZERO;
            end
        endcase
        in_ent = {c_op, c_p1, c_p2, p3_i, c_tag, c_val};
    end

    logic [ENT_W-1:0] m_q, m_d, s_q, s_d;
    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, drain;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        cnt_d     = cnt_q;
        accept    = in_valid_i & ~s_valid_q;
        drain     = m_valid_q & out_ready_i;
        if (drain && m_q[N] && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
        if (drain) begin
            // accept is impossible while S is occupied, so the S refill never races a new op
            if (s_valid_q) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d = in_ent;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q) begin
                m_d       = in_ent;
                m_valid_d = 1'b1;
            end else begin
                s_d       = in_ent;
                s_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign {op_o, p1_o, p2_o, p3_o, special_tag_o, special_val_o} = m_q;
    assign out_valid_o   = m_valid_q;
    assign in_ready_o    = ~s_valid_q;
    assign special_cnt_o = cnt_q;

endmodule

// File: tb/tb_ppu_input_stage.sv
// tb/tb_ppu_input_stage.sv - directed and random checks of ppu_input_stage against a queue model
module tb_ppu_input_stage;
    import ppu_input_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] p1 = 16'h0, p2 = 16'h0, p3 = 16'h0;

    logic        in_ready, out_valid, tag;
    logic [2:0]  op_o;
    logic [15:0] p1_o, p2_o, p3_o, val, cnt;
    logic        in_ready_b, out_valid_b, tag_b;
    logic [2:0]  op_b;
    logic [15:0] p1_b, p2_b, p3_b, val_b;
    logic [1:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ppu_input_stage #(.N(16), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .p1_i(p1), .p2_i(p2), .p3_i(p3),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .op_o(op_o),
        .p1_o(p1_o), .p2_o(p2_o), .p3_o(p3_o),
        .special_tag_o(tag), .special_val_o(val), .special_cnt_o(cnt));

    ppu_input_stage #(.N(16), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
        .op_i(op), .p1_i(p1), .p2_i(p2), .p3_i(p3),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .op_o(op_b),
        .p1_o(p1_b), .p2_o(p2_b), .p3_o(p3_b),
        .special_tag_o(tag_b), .special_val_o(val_b), .special_cnt_o(cnt_b));

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] p1, p2, p3;
        logic        tag;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_m  = 0;
    int   cnt2_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] neg(input logic [15:0] x);
        return 16'h0000 - x;
    endfunction

    function automatic logic [15:0] mag(input logic [15:0] x);
        return x[15] ? neg(x) : x;
    endfunction

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, b, c);
        exp_t r;
        logic [15:0] q = (o == OP_SUB) ? neg(b) : b;
        bit addsub = (o == OP_ADD) || (o == OP_SUB);
        bit nar = (a == 16'h8000) || (b == 16'h8000) || (o == OP_FMADD && c == 16'h8000);
        r.op  = (o == OP_SUB) ? 3'(OP_ADD) : o;
        r.p1  = (addsub && mag(q) > mag(a)) ? q : a;
        r.p2  = (addsub && mag(q) > mag(a)) ? a : q;
        r.p3  = c;
        r.tag = 1'b1;
        r.val = 16'h0000;
        if (o == OP_F2P || o == OP_P2F || o == 3'd7)      r.tag = 1'b0;
        else if (nar)                                    r.val = 16'h8000;
        else if (o == OP_DIV && b == 0)                  r.val = 16'h8000;
        else if (o == OP_DIV && a == 0)                  r.val = 16'h0000;
        else if (o == OP_MUL && (a == 0 || b == 0))      r.val = 16'h0000;
        else if (o == OP_FMADD && (a == 0 || b == 0))    r.val = c;
        else if (addsub && a == 0)                       r.val = q;
        else if (addsub && b == 0)                       r.val = a;
        else if (addsub && (a + q) == 16'h0000)          r.val = 16'h0000;
        else                                             r.tag = 1'b0;
        return r;
    endfunction

    // Mid-cycle monitor: compare the presented op to the model queue head, then record transfers
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt_m  = 0;
            cnt2_m = 0;
        end else begin
            check("out_valid", out_valid, exp_q.size() > 0);
            check("in_ready", in_ready, exp_q.size() < 2);
            check("cnt", cnt, cnt_m);
            check("cnt_sat", cnt_b, cnt2_m);
            if (out_valid && exp_q.size() > 0) begin
                check("op_o", op_o, exp_q[0].op);
                check("p1_o", p1_o, exp_q[0].p1);
                check("p2_o", p2_o, exp_q[0].p2);
                check("p3_o", p3_o, exp_q[0].p3);
                check("tag", tag, exp_q[0].tag);
                check("val", val, exp_q[0].val);
                if (out_ready) begin
                    if (exp_q[0].tag) begin
                        if (cnt_m < 65535) cnt_m++;
                        if (cnt2_m < 3) cnt2_m++;
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(op, p1, p2, p3));
        end
    end

    task automatic send(input logic [2:0] o, input logic [15:0] a, b, c);
        int n = 0;
        op = o; p1 = a; p2 = b; p3 = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cnt", cnt, 0);
        check("rst_p1_o", p1_o, 0);

        out_ready = 1'b1;
        send(OP_SUB, 16'h3000, 16'h5000, 16'h0);
        check("t1_op", op_o, OP_ADD);
        check("t1_p1", p1_o, 16'hB000);
        check("t1_p2", p2_o, 16'h3000);
        check("t1_tag", tag, 0);

        send(OP_MUL, 16'h0000, 16'h4000, 16'h0);
        check("t2_tag", tag, 1);
        check("t2_val", val, 16'h0000);
        check("t2_cnt0", cnt, 0);
        send(OP_FMADD, 16'h4000, 16'h8000, 16'h4000);
        check("t2_cnt1", cnt, 1);
        check("t2_fm_tag", tag, 1);
        check("t2_fm_val", val, 16'h8000);
        step();
        check("t2_cnt2", cnt, 2);
        check("t2_idle", out_valid, 0);

        out_ready = 1'b0;
        op = OP_MUL; p1 = 16'h1000; p2 = 16'h2000; p3 = 16'h0; in_valid = 1'b1;
        step();
        p1 = 16'h1100;
        step();
        p1 = 16'h1200;
        check("t3_stall_ready", in_ready, 0);
        check("t3_head", p1_o, 16'h1000);
        step();
        check("t3_hold", p1_o, 16'h1000);
        out_ready = 1'b1;
        step();
        check("t3_second", p1_o, 16'h1100);
        check("t3_ready_back", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("t3_third", p1_o, 16'h1200);
        step();
        check("t3_drained", out_valid, 0);

        send(OP_ADD, 16'h4000, 16'hC000, 16'h0);
        check("t4_add_tag", tag, 1);
        check("t4_add_val", val, 16'h0000);
        send(OP_DIV, 16'h4000, 16'h0000, 16'h0);
        check("t4_div_val", val, 16'h8000);
        send(OP_F2P, 16'h0000, 16'h0000, 16'h0);
        check("t4_f2p_tag", tag, 0);
        step();

        out_ready = 1'b0;
        op = OP_MUL; p1 = 16'h0; p2 = 16'h1; in_valid = 1'b1;
        step();
        p2 = 16'h2;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_cnt", cnt, 0);
        check("t5_op_o", op_o, 0);
        check("t5_val", val, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(OP_MUL, 16'h0000, 16'h1234, 16'h0);
        step();
        check("t6_cnt_sat", cnt_b, 3);
        check("t6_cnt_full", cnt, 5);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] pool [8];
            pool[0] = 16'h0000; pool[1] = 16'h8000; pool[2] = 16'h4000; pool[3] = 16'hC000;
            pool[4] = 16'h3000; pool[5] = 16'hD000; pool[6] = 16'($urandom); pool[7] = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 6));
            p1 = pool[$urandom_range(0, 7)];
            p2 = pool[$urandom_range(0, 7)];
            p3 = pool[$urandom_range(0, 7)];
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("end_empty", exp_q.size(), 0);
        check("end_out_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
